// File: rtl/alu_cmd_ctrl.sv
// Command front-end around a 64-bit ALU: carry chaining plus an in-order response FIFO.
// Optional per-entry zero/negative flags are built when ALU_CMD_FLAGS_EN is defined.

module alu64bit (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [1:0]  i_op,
    input  logic        i_cin,
    output logic [63:0] o_s,
    output logic        o_cout
);

    logic [64:0] w_sum;

    // SUB is a + ~b + cin, so cin=1 gives a true a-b and cout=1 means no borrow.
    // Logic ops report a carry-out of 0.
    always_comb begin
        w_sum  = '0;
        o_s    = '0;
        o_cout = 1'b0;
        unique case (i_op)
            2'b00: o_s = ~(i_a | i_b);
            2'b01: o_s = i_a ^ i_b;
            2'b10: begin
                w_sum  = {1'b0, i_a} + {1'b0, i_b} + {64'd0, i_cin};
                o_s    = w_sum[63:0];
                o_cout = w_sum[64];
            end
            2'b11: begin
                w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {64'd0, i_cin};
                o_s    = w_sum[63:0];
                o_cout = w_sum[64];
            end
            default: ;
        endcase
    end

endmodule

module alu_cmd_ctrl #(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_op,
    input  logic        req_cin,
    input  logic        req_chain,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_s,
    output logic        rsp_cout
`ifdef ALU_CMD_FLAGS_EN
    ,
    output logic        rsp_zero,
    output logic        rsp_neg
`endif
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RSP_DEPTH);

    logic          r_carry;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_mem_s [RSP_DEPTH];
    logic          r_mem_c [RSP_DEPTH];
`ifdef ALU_CMD_FLAGS_EN
    logic          r_mem_z [RSP_DEPTH];
    logic          r_mem_n [RSP_DEPTH];
`endif

    logic          w_cin;
    logic [63:0]   w_s;
    logic          w_cout;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_d;
    logic [PW-1:0] w_rd_ptr_d;
    logic [PW-1:0] w_wr_ptr_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign w_cin = req_chain ? r_carry : req_cin;

    alu64bit u_alu (
        .i_a    (req_a),
        .i_b    (req_b),
        .i_op   (req_op),
        .i_cin  (w_cin),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Ready is purely from registered occupancy: a full buffer never takes a
    // push in the same cycle it pops.
    assign req_ready = (r_count < CNT_MAX);
    assign rsp_valid = (r_count != '0);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

    assign rsp_s    = r_mem_s[r_rd_ptr];
    assign rsp_cout = r_mem_c[r_rd_ptr];
`ifdef ALU_CMD_FLAGS_EN
    assign rsp_zero = r_mem_z[r_rd_ptr];
    assign rsp_neg  = r_mem_n[r_rd_ptr];
`endif

    always_comb begin
        w_count_d  = r_count;
        w_rd_ptr_d = r_rd_ptr;
        w_wr_ptr_d = r_wr_ptr;
        if (w_push) begin
            w_wr_ptr_d = ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
            w_rd_ptr_d = ptr_inc(r_rd_ptr);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry  <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_count  <= w_count_d;
            if (w_push) begin
                r_carry <= w_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem_s[i] <= '0;
                r_mem_c[i] <= 1'b0;
`ifdef ALU_CMD_FLAGS_EN
                r_mem_z[i] <= 1'b0;
                r_mem_n[i] <= 1'b0;
`endif
            end
        end else if (w_push) begin
            r_mem_s[r_wr_ptr] <= w_s;
            r_mem_c[r_wr_ptr] <= w_cout;
`ifdef ALU_CMD_FLAGS_EN
            r_mem_z[r_wr_ptr] <= (w_s == 64'd0);
            r_mem_n[r_wr_ptr] <= w_s[63];
`endif
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed corner cases with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.

module tb_alu_cmd_ctrl;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [1:0]  req_op = '0;
    logic        req_cin = 1'b0;
    logic        req_chain = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_s;
    logic        rsp_cout;
`ifdef ALU_CMD_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_neg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the FIFO contents and the stored carry.
    logic [63:0] mq_s[$];
    logic        mq_c[$];
    logic        m_carry = 1'b0;

    alu_cmd_ctrl #(.RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
`ifdef ALU_CMD_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // {cout, s}; SUB is a + ~b + cin.
    function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op, input logic cin);
        logic [64:0] ea;
        logic [64:0] eb;
        logic [64:0] ec;
        ea = {1'b0, a};
        ec = {64'd0, cin};
        case (op)
            2'b00:   return {1'b0, ~(a | b)};
            2'b01:   return {1'b0, a ^ b};
            2'b10:   begin eb = {1'b0, b};  return ea + eb + ec; end
            default: begin eb = {1'b0, ~b}; return ea + eb + ec; end
        endcase
    endfunction

    task automatic check_model();
        chk("req_ready", {63'd0, req_ready}, {63'd0, (mq_s.size() < DEPTH)});
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, (mq_s.size() != 0)});
        if (mq_s.size() != 0) begin
            chk("rsp_s", rsp_s, mq_s[0]);
            chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, mq_c[0]});
`ifdef ALU_CMD_FLAGS_EN
            chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, (mq_s[0] == 64'd0)});
            chk("rsp_neg", {63'd0, rsp_neg}, {63'd0, mq_s[0][63]});
`endif
        end
    endtask

    task automatic update_model();
        logic        acc;
        logic        pop;
        logic [64:0] r;
        acc = req_valid && (mq_s.size() < DEPTH);
        pop = rsp_ready && (mq_s.size() != 0);
        r   = ref_alu(req_a, req_b, req_op, req_chain ? m_carry : req_cin);
        if (pop) begin
            void'(mq_s.pop_front());
            void'(mq_c.pop_front());
        end
        if (acc) begin
            mq_s.push_back(r[63:0]);
            mq_c.push_back(r[64]);
            m_carry = r[64];
        end
    endtask

    // Compare at the falling edge, advance the model, then land 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic cin, input logic chain);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_cin   = cin;
        req_chain = chain;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst rsp_s", rsp_s, 64'd0);
        chk("rst rsp_cout", {63'd0, rsp_cout}, 64'd0);
        chk("rst req_ready", {63'd0, req_ready}, 64'd1);
        mq_s.delete();
        mq_c.delete();
        m_carry = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Wrap-around ADD, then chained ADD consuming the stored carry.
        rsp_ready = 1'b1;
        req(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 1'b0);
        cycle();
        chk("add wrap valid", {63'd0, rsp_valid}, 64'd1);
        chk("add wrap s", rsp_s, 64'h0);
        chk("add wrap cout", {63'd0, rsp_cout}, 64'd1);
`ifdef ALU_CMD_FLAGS_EN
        chk("add wrap zero", {63'd0, rsp_zero}, 64'd1);
`endif
        req(1'b1, 64'h0, 64'h0, 2'b10, 1'b0, 1'b1);
        cycle();
        chk("chain s", rsp_s, 64'h1);
        chk("chain cout", {63'd0, rsp_cout}, 64'd0);

        // Set carry, then XOR must overwrite it with its cout of 0.
        req(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 1'b0);
        cycle();
        req(1'b1, 64'hF0F0, 64'hFF00, 2'b01, 1'b1, 1'b0);
        cycle();
        chk("xor s", rsp_s, 64'h0FF0);
        chk("xor cout", {63'd0, rsp_cout}, 64'd0);
        req(1'b1, 64'h0, 64'h0, 2'b10, 1'b1, 1'b1);
        cycle();
        chk("chain after xor s", rsp_s, 64'h0);
        req(1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        cycle();
        chk("drained", {63'd0, rsp_valid}, 64'd0);

        // Back-pressure: two accepted, third held until the first pop.
        rsp_ready = 1'b0;
        req(1'b1, 64'd10, 64'd1, 2'b10, 1'b0, 1'b0);
        cycle();
        chk("bp ready1", {63'd0, req_ready}, 64'd1);
        req(1'b1, 64'd20, 64'd2, 2'b10, 1'b0, 1'b0);
        cycle();
        chk("bp ready full", {63'd0, req_ready}, 64'd0);
        req(1'b1, 64'd30, 64'd3, 2'b10, 1'b0, 1'b0);
        cycle();
        chk("bp held ready", {63'd0, req_ready}, 64'd0);
        chk("bp held head", rsp_s, 64'd11);
        rsp_ready = 1'b1;
        cycle();
        chk("pop only head", rsp_s, 64'd22);
        chk("pop only ready", {63'd0, req_ready}, 64'd1);
        cycle();
        chk("push+pop head", rsp_s, 64'd33);
        chk("push+pop valid", {63'd0, rsp_valid}, 64'd1);
        req(1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        cycle();
        chk("bp drained", {63'd0, rsp_valid}, 64'd0);

        // Reset mid-stream with two buffered responses and carry set.
        rsp_ready = 1'b0;
        req(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 1'b0);
        cycle();
        cycle();
        do_reset();
        rsp_ready = 1'b1;
        req(1'b1, 64'h0, 64'h0, 2'b10, 1'b0, 1'b1);
        cycle();
        chk("post-rst chain s", rsp_s, 64'h0);
        chk("post-rst chain cout", {63'd0, rsp_cout}, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req($urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(),
                2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            rsp_ready = $urandom_range(0, 2) != 0;
            if (i % 700 == 699) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter: RSP_DEPTH, default 2, number of entries in the response buffer (legal range 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  block can accept a request this cycle.
REQ-006 Port: req_a  input  64  operand a.
REQ-007 Port: req_b  input  64  operand b.
REQ-008 Port: req_op  input  2  operation: 00 NOR, 01 XOR, 10 ADD, 11 SUB.
REQ-009 Port: req_cin  input  1  carry-in, used when req_chain=0.
REQ-010 Port: req_chain  input  1  1 = use the stored carry from the previous accepted request as carry-in.
REQ-011 Port: rsp_valid  output  1  response buffer non-empty.
REQ-012 Port: rsp_ready  input  1  consumer accepts the head response.
REQ-013 Port: rsp_s  output  64  head-entry result.
REQ-014 Port: rsp_cout  output  1  head-entry carry-out.

Function
REQ-015 The block SHALL instantiate exactly one alu64bit and drive it combinationally from req_a, req_b, req_op and the effective carry-in.
REQ-016 Effective carry-in SHALL be carry_q when req_chain=1, else req_cin.
REQ-017 A request SHALL be accepted in a cycle where req_valid=1 and req_ready=1.
REQ-018 On acceptance, {s, cout} SHALL be pushed into the response buffer, and carry_q SHALL be loaded with cout, for every op.
REQ-019 Latency SHALL be exactly 1 cycle: the response is visible on rsp_valid/rsp_s/rsp_cout in the cycle after acceptance when the buffer was empty.
REQ-020 The response buffer SHALL be an in-order FIFO of RSP_DEPTH entries with a wrap-around read pointer, a write pointer, and an occupancy count of 0..RSP_DEPTH.
REQ-021 req_ready SHALL equal (count < RSP_DEPTH) from registered state only; there is no same-cycle pop-to-push pass-through when full.
REQ-022 A pop SHALL occur in a cycle where rsp_valid=1 and rsp_ready=1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Pointers SHALL wrap from RSP_DEPTH-1 to 0.
REQ-025 rsp_valid SHALL equal (count != 0).
REQ-026 rsp_s/rsp_cout SHALL always reflect the entry at the read pointer, and SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-027 carry_q SHALL NOT change in cycles without acceptance, including cycles with req_valid=1 and req_ready=0.

Reset
REQ-028 While rst_n=0, count, both pointers and carry_q SHALL be 0, and all buffer entries SHALL be 0.
REQ-029 Outputs during and after reset: rsp_valid=0, rsp_s=0, rsp_cout=0, req_ready=1.
REQ-030 Reset asserted mid-stream SHALL discard all buffered responses and the stored carry, with no partial push or pop completing.

Configuration
REQ-031 With macro ALU_CMD_FLAGS_EN defined, the block SHALL add outputs rsp_zero (1 = head rsp_s equals 0) and rsp_neg (head rsp_s[63]); both SHALL be stored per entry and reset to 0.
REQ-032 Without ALU_CMD_FLAGS_EN, these ports and their storage SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 ADD request with a=0xFFFFFFFFFFFFFFFF, b=0x1, cin=0, chain=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_s=0x0, rsp_cout=1 (and rsp_zero=1 with flags).
REQ-034 Immediately follow with ADD request a=0, b=0, chain=1, req_cin=0 -> rsp_s=0x1, rsp_cout=0 (stored carry used, req_cin ignored).
REQ-035 XOR request with a=0xF0F0, b=0xFF00 -> rsp_s=0x0FF0, and carry_q is updated with the returned cout.
REQ-036 RSP_DEPTH=2, rsp_ready=0, three back-to-back requests -> two are accepted, then req_ready=0 and the third is held; with rsp_ready=1 the responses drain in order and req_ready returns to 1 the cycle after the first pop.
REQ-037 Full buffer with simultaneous rsp_ready=1 and req_valid=1 -> pop only (no push that cycle); then alternate push/pop on a non-full buffer -> count stays constant and pointers wrap correctly.
REQ-038 Assert rst_n=0 with 2 responses buffered and carry_q=1 -> rsp_valid=0 and rsp_s=0 immediately; a chained ADD 0+0 after reset -> rsp_s=0x0.
